// File: rtl/sprite_palette_if.sv
// sprite_palette_if
//   Bundles the lookup, palette-write, flash-control and result signals of
//   sprite_palette_engine. The engine connects through the slave modport and
//   the pixel/host side drives through the master modport.
//
//   Handshake semantics:
//     - Lookup: pix_valid has no ready. The engine accepts one request per
//       cycle while running and answers with out_valid exactly two cycles later.
//     - Write: a write happens on a rising edge where wr_en and wr_ready are
//       both 1. wr_ready is 0 while the palette is being cleared.
//     - frame_start and flash_start are single-cycle pulses.
//
//   Signals (master view):
//     pix_valid, bank_sel, index             lookup request
//     wr_en, wr_bank, wr_idx, wr_rgb         palette write
//     wr_ready                               engine accepts writes
//     frame_start, flash_start               flash timing pulses
//     out_valid, red, green, blue            lookup result
//     transparent                            result equals the key colour
//     flash_active                           flash window running
//     fsm_state                              engine state (0 INIT, 1 RUN)
interface sprite_palette_if #(
    parameter int IDX_W  = 4,
    parameter int BANK_W = 4
);
    logic              pix_valid;
    logic [BANK_W-1:0] bank_sel;
    logic [IDX_W-1:0]  index;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [11:0]       wr_rgb;
    logic              wr_ready;
    logic              frame_start;
    logic              flash_start;
    logic              out_valid;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic              transparent;
    logic              flash_active;
    logic [0:0]        fsm_state;

    modport master (
        output pix_valid, bank_sel, index,
        output wr_en, wr_bank, wr_idx, wr_rgb,
        output frame_start, flash_start,
        input  wr_ready, out_valid, red, green, blue, transparent,
        input  flash_active, fsm_state
    );

    modport slave (
        input  pix_valid, bank_sel, index,
        input  wr_en, wr_bank, wr_idx, wr_rgb,
        input  frame_start, flash_start,
        output wr_ready, out_valid, red, green, blue, transparent,
        output flash_active, fsm_state
    );
endinterface

// File: rtl/sprite_palette_engine.sv
// sprite_palette_engine
//   Banked sprite palette with a two-stage lookup pipeline, transparency-key
//   detection and a frame-counted white hit-flash.
//
//   After reset the engine walks every entry of every bank (bank-major) and
//   writes KEY_COLOR, one entry per cycle, then switches to RUN.
//
//   Ports:
//     clk   sole clock, rising edge
//     rst   synchronous active-high reset
//     bus   sprite_palette_if slave modport (lookup, write, flash, result)
module sprite_palette_engine #(
    parameter int          IDX_W        = 4,
    parameter int          NUM_BANKS    = 9,
    parameter int          BANK_W       = 4,
    parameter logic [11:0] KEY_COLOR    = 12'hF0F,
    parameter int          FLASH_FRAMES = 16
) (
    input logic            clk,
    input logic            rst,
    sprite_palette_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int DEPTH   = NUM_BANKS * ENTRIES;
    localparam int ADDR_W  = BANK_W + IDX_W;
    localparam int CNT_W   = $clog2(FLASH_FRAMES + 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] init_ptr;

    logic [11:0]       mem [DEPTH];

    // Bank-major layout: {bank, idx} is bank*ENTRIES + idx.
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_ok;
    logic              rd_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [11:0]       mem_wdata;

    logic              s1_valid;
    logic              s1_oob;
    logic [11:0]       s1_rgb;
    logic              s1_trans;

    logic [CNT_W-1:0]  flash_cnt;
    logic              flash_active;
    logic              flash_on;

    logic              out_valid;
    logic              transparent;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;

    assign wr_addr = {bus.wr_bank, bus.wr_idx};
    assign rd_addr = {bus.bank_sel, bus.index};
    assign wr_ok   = int'(bus.wr_bank) < NUM_BANKS;
    assign rd_ok   = int'(bus.bank_sel) < NUM_BANKS;

    // Clear walk and external writes share the single write port; external
    // writes are only possible in RUN, so there is never a conflict.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_ptr;
        mem_wdata = KEY_COLOR;
        if (!rst) begin
            if (state == ST_INIT) begin
                mem_we = 1'b1;
            end else if (bus.wr_en && wr_ok) begin
                mem_we    = 1'b1;
                mem_waddr = wr_addr;
                mem_wdata = bus.wr_rgb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else if (state == ST_INIT) begin
            if (init_ptr == ADDR_W'(DEPTH - 1)) begin
                state <= ST_RUN;
            end else begin
                init_ptr <= init_ptr + 1'b1;
            end
        end
    end

    // Stage 1: read the palette. A same-edge write is not yet visible, so a
    // simultaneous write and lookup of one entry returns the old colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_oob   <= 1'b0;
            s1_rgb   <= '0;
        end else begin
            s1_valid <= bus.pix_valid && (state == ST_RUN);
            s1_oob   <= !rd_ok;
            s1_rgb   <= rd_ok ? mem[rd_addr] : 12'h000;
        end
    end

    // Out-of-range banks read as transparent so bad sprites vanish rather
    // than showing garbage.
    assign s1_trans = s1_oob || (s1_rgb == KEY_COLOR);
    // White on odd counter values gives an alternating-frame flicker.
    assign flash_on = flash_active && flash_cnt[0];

    // Stage 2: apply transparency and flash, register the outputs.
    always_ff @(posedge clk) begin
        if (rst || !s1_valid) begin
            out_valid   <= 1'b0;
            transparent <= 1'b0;
            red         <= 4'h0;
            green       <= 4'h0;
            blue        <= 4'h0;
        end else begin
            out_valid   <= 1'b1;
            transparent <= s1_trans;
            if (s1_trans) begin
                {red, green, blue} <= 12'h000;
            end else if (flash_on) begin
                {red, green, blue} <= 12'hFFF;
            end else begin
                {red, green, blue} <= s1_rgb;
            end
        end
    end

    // Flash window: a hit reloads the counter (even over a frame pulse), and
    // each frame while active counts down; the window closes as it hits 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            flash_cnt    <= '0;
            flash_active <= 1'b0;
        end else if (state == ST_RUN) begin
            if (bus.flash_start) begin
                flash_cnt    <= CNT_W'(FLASH_FRAMES);
                flash_active <= 1'b1;
            end else if (bus.frame_start && flash_active) begin
                flash_cnt <= flash_cnt - 1'b1;
                if (flash_cnt == CNT_W'(1)) begin
                    flash_active <= 1'b0;
                end
            end
        end
    end

    assign bus.wr_ready     = (state == ST_RUN);
    assign bus.out_valid    = out_valid;
    assign bus.transparent  = transparent;
    assign bus.red          = red;
    assign bus.green        = green;
    assign bus.blue         = blue;
    assign bus.flash_active = flash_active;
    assign bus.fsm_state    = state;
endmodule
